// File: rtl/ps2_pkg.sv
// PS/2 shared types: host-tx state enum, frame size, parity helper, commands.
// Imported by the host transmitter and reusable by the receive path.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam int FRAME_TX_BITS = 10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte handshake between a command source and ps2_host_tx.
// master: source side (data/valid out); slave: transmitter (ready/done/err out).
interface ps2_host_tx_if;

  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       tx_done_o;
  logic       tx_err_o;

  modport master (
    output tx_data_i, tx_valid_i,
    input  tx_ready_o, tx_done_o, tx_err_o
  );

  modport slave (
    input  tx_data_i, tx_valid_i,
    output tx_ready_o, tx_done_o, tx_err_o
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// PS/2 pad synchronizer: SYNC_STAGES flops on clock and data, falling-edge pulse.
// Ports: clk_i, reset_n, ps2_clk_i, ps2_data_i -> clk_s_o, data_s_o, fall_o.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s_o,
  output logic data_s_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] clk_q;
  logic [SYNC_STAGES-1:0] data_q;
  logic                   prev_q;

  // Reset to the idle bus level so no false edge follows reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      clk_q  <= '1;
      data_q <= '1;
      prev_q <= 1'b1;
    end else begin
      clk_q  <= {clk_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_q <= {data_q[SYNC_STAGES-2:0], ps2_data_i};
      prev_q <= clk_q[SYNC_STAGES-1];
    end
  end

  assign clk_s_o  = clk_q[SYNC_STAGES-1];
  assign data_s_o = data_q[SYNC_STAGES-1];
  assign fall_o   = prev_q & ~clk_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift, ACK check.
// Ports: clk_i, reset_n, tx_if (slave: data/valid/ready/done/err),
//   ps2_clk_i, ps2_data_i, ps2_clk_oe_o, ps2_data_oe_o, busy_o.
// Option: define PS2_TX_TIMEOUT_EN for a request-to-ACK watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1440,
  parameter int TIMEOUT_CYCLES = 204000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic         clk_i,
  input  logic         reset_n,
  ps2_host_tx_if.slave tx_if,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o,
  output logic         busy_o
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_t state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          oe_q, oe_d;
  logic          eflag_q, eflag_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic clk_s, data_s, fall;
  logic inh_last;
  logic accept;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .ps2_clk_i (ps2_clk_i),
    .ps2_data_i(ps2_data_i),
    .clk_s_o   (clk_s),
    .data_s_o  (data_s),
    .fall_o    (fall)
  );

  assign accept   = tx_if.tx_valid_i && (state_q == IDLE);
  assign inh_last = (state_q == INHIBIT) &&
                    (cnt_q == IW'(INHIBIT_CYCLES - 1));

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q;
  logic          wd_run;
  logic          wd_hit;

  // Counts from REQ entry; INHIBIT time is not part of the budget.
  assign wd_run = (state_q != IDLE) && (state_q != INHIBIT);
  assign wd_hit = ((state_q == REQ) || (state_q == SEND) ||
                   (state_q == ACK)) &&
                  (wd_q == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!reset_n || state_q == IDLE) begin
      wd_q <= '0;
    end else if (wd_run && wd_q != WW'(TIMEOUT_CYCLES)) begin
      wd_q <= wd_q + WW'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    oe_d    = oe_q;
    eflag_d = eflag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          shift_d = {1'b1, odd_parity(tx_if.tx_data_i),
                     tx_if.tx_data_i};
          eflag_d = 1'b0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_last) begin
          bit_d   = '0;
          state_d = REQ;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      REQ: begin
        if (fall) begin
          oe_d    = ~shift_q[0];
          bit_d   = 4'd1;
          state_d = SEND;
        end
      end
      // bit_q indexes the next bit; index 9 is the stop bit (release).
      SEND: begin
        if (fall) begin
          oe_d  = ~shift_q[bit_q];
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'(FRAME_TX_BITS - 1)) begin
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (fall) begin
          if (data_s) begin
            err_d   = 1'b1;
            eflag_d = 1'b1;
          end
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = ~eflag_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (wd_hit) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      oe_q    <= 1'b0;
      eflag_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      oe_q    <= oe_d;
      eflag_q <= eflag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Start bit goes low in the last inhibit cycle and holds through REQ.
  assign ps2_clk_oe_o  = (state_q == INHIBIT);
  assign ps2_data_oe_o = inh_last || (state_q == REQ) ||
                         ((state_q == SEND) && oe_q);

  assign tx_if.tx_ready_o = (state_q == IDLE);
  assign tx_if.tx_done_o  = done_q;
  assign tx_if.tx_err_o   = err_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Vector table, random frames vs. frame model, reset/busy/timeout sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TO   = 3000;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic clk_oe, data_oe, busy;
  wire  bus_clk  = dev_clk & ~clk_oe;
  wire  bus_data = dev_data & ~data_oe;

  ps2_host_tx_if tx_if();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i        (clk),
    .reset_n      (reset_n),
    .tx_if        (tx_if),
    .ps2_clk_i    (bus_clk),
    .ps2_data_i   (bus_data),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe),
    .busy_o       (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   inh_cnt = 0, inh_doe_cnt = 0, frames = 0;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (tx_if.tx_done_o) done_cnt++;
    if (tx_if.tx_err_o) err_cnt++;
    if (tx_if.tx_done_o && tx_if.tx_err_o) both_cnt++;
    if (clk_oe) inh_cnt++;
    if (clk_oe && data_oe) inh_doe_cnt++;
    if (busy && !busy_prev) frames++;
    busy_prev = busy;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         exp_done;
    int         exp_err;
  } vec_t;

  function automatic logic [10:0] model_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = ($countones(d) % 2 == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (tx_if.tx_ready_o) ok = 1;
    end
    chk({tag, " ready"}, ok, 1);
  endtask

  task automatic accept(input logic [7:0] d);
    @(negedge clk);
    tx_if.tx_data_i  = d;
    tx_if.tx_valid_i = 1'b1;
    @(negedge clk);
    tx_if.tx_valid_i = 1'b0;
  endtask

  // Device: waits for request, clocks 11 pulses, samples on rising edges.
  task automatic dev_frame(input bit ack, input int abort_at,
                           output logic [10:0] bits, output bit got);
    got  = 0;
    bits = '0;
    for (int k = 0; k < INH * 4 + 50 && !got; k++) begin
      @(negedge clk);
      if (!clk_oe && data_oe) got = 1;
    end
    if (!got) return;
    repeat (HALF) @(negedge clk);
    bits[0] = bus_data;
    for (int i = 1; i <= 11; i++) begin
      dev_clk = 1'b0;
      if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
      if (i == abort_at) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) bits[i] = bus_data;
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_data = 1'b1;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d,
                           input bit ack, input int exp_done,
                           input int exp_err, input bit inject);
    logic [10:0] bits, exp;
    bit          got;
    int          d0, e0, i0, j0, f0;
    wait_ready({tag, " pre"});
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
    j0 = inh_doe_cnt; f0 = frames;
    accept(d);
    if (inject) begin
      repeat (3) @(negedge clk);
      chk({tag, " busy"}, busy, 1);
      tx_if.tx_data_i  = 8'h55;
      tx_if.tx_valid_i = 1'b1;
      repeat (2) @(negedge clk);
      tx_if.tx_valid_i = 1'b0;
    end
    dev_frame(ack, 0, bits, got);
    chk({tag, " request"}, got, 1);
    exp = model_frame(d);
    for (int i = 0; i <= 10; i++)
      chk($sformatf("%s bit%0d", tag, i), bits[i], exp[i]);
    wait_ready({tag, " post"});
    repeat (2) @(negedge clk);
    chk({tag, " done"}, done_cnt - d0, exp_done);
    chk({tag, " err"}, err_cnt - e0, exp_err);
    chk({tag, " inhibit_len"}, inh_cnt - i0, INH);
    chk({tag, " start_in_inh"}, inh_doe_cnt - j0, 1);
    chk({tag, " frames"}, frames - f0, 1);
  endtask

  vec_t tv[4];

  initial begin
    logic [10:0] bits;
    bit          got;
    int          d0, e0, f0;
    logic [7:0]  rd;
    bit          rack;

    tx_if.tx_data_i  = 8'h00;
    tx_if.tx_valid_i = 1'b0;

    tv[0] = '{CMD_SET_LED, 1'b1, 1, 0};
    tv[1] = '{8'h01,       1'b1, 1, 0};
    tv[2] = '{8'h00,       1'b1, 1, 0};
    tv[3] = '{CMD_RESET,   1'b0, 0, 1};

    repeat (3) @(negedge clk);
    chk("rst ready", tx_if.tx_ready_o, 1);
    chk("rst busy", busy, 0);
    chk("rst clk_oe", clk_oe, 0);
    chk("rst data_oe", data_oe, 0);
    chk("rst done", tx_if.tx_done_o, 0);
    chk("rst err", tx_if.tx_err_o, 0);
    reset_n = 1'b1;

    for (int v = 0; v < 4; v++)
      run_frame($sformatf("vec%0d", v), tv[v].data, tv[v].ack,
                tv[v].exp_done, tv[v].exp_err, 1'b0);

    // Reset at fall 5: lines released, no pulses, then a clean frame.
    wait_ready("abort pre");
    d0 = done_cnt; e0 = err_cnt;
    accept(8'hA5);
    dev_frame(1'b1, 5, bits, got);
    chk("abort request", got, 1);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort clk_oe", clk_oe, 0);
    chk("abort data_oe", data_oe, 0);
    chk("abort ready", tx_if.tx_ready_o, 1);
    chk("abort busy", busy, 0);
    reset_n = 1'b1;
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort done", done_cnt - d0, 0);
    chk("abort err", err_cnt - e0, 0);
    run_frame("after_abort", 8'hF4, 1'b1, 1, 0, 1'b0);

    // Request while busy is dropped, not queued.
    run_frame("busy_ign", 8'hC3, 1'b1, 1, 0, 1'b1);
    f0 = frames;
    repeat (100) @(negedge clk);
    chk("busy_ign no_queue", frames - f0, 0);
    chk("busy_ign idle", busy, 0);

    for (int r = 0; r < 8; r++) begin
      rd   = 8'($urandom);
      rack = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", r), rd, rack,
                rack ? 1 : 0, rack ? 0 : 1, 1'b0);
    end

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int  n;
      bit  seen;
      wait_ready("to pre");
      accept(8'h12);
      seen = 0;
      for (int k = 0; k < INH * 4 && !seen; k++) begin
        @(negedge clk);
        if (!clk_oe && data_oe) seen = 1;
      end
      chk("to request", seen, 1);
      n = 0;
      for (int k = 0; k < TO + 100; k++) begin
        @(negedge clk);
        n++;
        if (tx_if.tx_err_o) break;
      end
      chk("to latency", n, TO);
      chk("to err", tx_if.tx_err_o, 1);
      chk("to clk_oe", clk_oe, 0);
      chk("to data_oe", data_oe, 0);
      chk("to ready", tx_if.tx_ready_o, 1);
    end
`endif

    chk("never_both", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
